// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - MEM-stage sequencer splitting 32-bit accesses into two 16-bit async SRAM half-accesses
module sram_mem_ctrl #(
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [16:0] word_addr;
    logic [31:0] wdata;
    logic        req;
    logic        last;
    logic [16:0] word_addr_in;

    assign req          = rd_en | wr_en;
    assign last         = (cnt == 4'(WAIT_CYCLES - 1));
    // Addresses below the base wrap silently within the 17-bit word space.
    assign word_addr_in = 17'((address - BASE_ADDR) >> 2);
    assign ready        = ~(req & (state != DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LOW;
            LOW:     if (last) state_nxt = HIGH;
            HIGH:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_wr     <= 1'b0;
            word_addr <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr     <= wr_en;
                        word_addr <= word_addr_in;
                        wdata     <= write_data;
                        cnt       <= '0;
                    end
                end
                LOW, HIGH: begin
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                    // Data has had the whole wait window to settle by the last clock.
                    if (!op_wr && last) begin
                        if (state == LOW) read_data[15:0]  <= sram_dq_in;
                        else              read_data[31:16] <= sram_dq_in;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_ce_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        if (state == LOW || state == HIGH) begin
            sram_ce_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            sram_addr = {word_addr, state == HIGH};
            if (op_wr) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - randomized bench with per-cycle behavioural model for sram_mem_ctrl
module tb_sram_mem_ctrl;

    localparam int W = 4;

    logic        clk;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, we_n, oe_n, ce_n, ub_n, lb_n;

    logic        rd_1;
    logic [31:0] addr_1, read_data_1;
    logic        ready_1;
    logic [17:0] sram_addr_1;
    logic [15:0] dq_out_1, dq_in_1;
    logic        dq_oe_1, we_n_1, oe_n_1, ce_n_1, ub_n_1, lb_n_1;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;

    sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
        .sram_dq_in(dq_in), .sram_dq_oe(dq_oe), .sram_we_n(we_n),
        .sram_oe_n(oe_n), .sram_ce_n(ce_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
        .clk(clk), .rst(rst_n), .wr_en(1'b0), .rd_en(rd_1),
        .address(addr_1), .write_data(32'h0), .read_data(read_data_1),
        .ready(ready_1), .sram_addr(sram_addr_1), .sram_dq_out(dq_out_1),
        .sram_dq_in(dq_in_1), .sram_dq_oe(dq_oe_1), .sram_we_n(we_n_1),
        .sram_oe_n(oe_n_1), .sram_ce_n(ce_n_1), .sram_ub_n(ub_n_1), .sram_lb_n(lb_n_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // External SRAM: halfword array, unwritten locations return a fixed pattern.
    logic [15:0] sram [int];
    logic [15:0] ref_half [int];

    function automatic logic [15:0] init_half(input int a);
        logic [31:0] t;
        t = a * 32'd40503 + 32'h1357;
        return t[15:0];
    endfunction

    function automatic logic [15:0] env_rd(input int a);
        if (sram.exists(a)) return sram[a];
        return init_half(a);
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        if (ref_half.exists(a)) return ref_half[a];
        return init_half(a);
    endfunction

    always @(posedge clk) begin
        if (!ce_n && !we_n && dq_oe) sram[int'(sram_addr)] = dq_out;
    end

    always @(negedge clk) begin
        dq_in = (!ce_n && !oe_n) ? env_rd(int'(sram_addr)) : 16'h0BAD;
        if (!we_n) we_cnt++;
    end

    assign dq_in_1 = (!ce_n_1 && !oe_n_1) ? (sram_addr_1[0] ? 16'hCAFE : 16'hF00D) : 16'h0BAD;

    // Reference: an access started at cycle 0 occupies low half in cycles 1..W,
    // high half in W+1..2W, and completes (ready) in cycle 2W+1.
    bit          busy = 0;
    int          k = 0;
    bit          m_wr;
    logic [16:0] m_w;
    logic [31:0] m_d;
    logic [31:0] exp_rd = 32'h0;

    task automatic check_idle_pins();
        check("ce_n", ce_n, 1'b1);
        check("we_n", we_n, 1'b1);
        check("oe_n", oe_n, 1'b1);
        check("ub_lb_n", {ub_n, lb_n}, 2'b11);
        check("dq_oe", dq_oe, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy   = 0;
            exp_rd = 32'h0;
            check("rst_ready", ready, !(rd_en | wr_en));
            check_idle_pins();
            check("rst_read_data", read_data, 32'h0);
        end else if (!busy) begin
            check("idle_ready", ready, !(rd_en | wr_en));
            check_idle_pins();
            check("idle_read_data", read_data, exp_rd);
            if (rd_en | wr_en) begin
                busy = 1;
                k    = 1;
                m_wr = wr_en;
                m_w  = 17'((address - 32'd1024) >> 2);
                m_d  = write_data;
            end
        end else begin
            check("busy_ready", ready, (k == 2*W+1) ? 1'b1 : !(rd_en | wr_en));
            check("busy_read_data", read_data, exp_rd);
            if (k <= 2*W) begin
                check("act_ce_ub_lb", {ce_n, ub_n, lb_n}, 3'b000);
                check("act_addr", sram_addr, {m_w, k > W});
                check("act_we_n", we_n, !m_wr);
                check("act_oe_n", oe_n, m_wr);
                check("act_dq_oe", dq_oe, m_wr);
                if (m_wr) check("act_dq_out", dq_out, (k > W) ? m_d[31:16] : m_d[15:0]);
            end else begin
                check_idle_pins();
            end
            if (m_wr) begin
                if (k == 1)   ref_half[2*int'(m_w)]     = m_d[15:0];
                if (k == W+1) ref_half[2*int'(m_w) + 1] = m_d[31:16];
            end else begin
                if (k == W)   exp_rd[15:0]  = ref_rd(2*int'(m_w));
                if (k == 2*W) exp_rd[31:16] = ref_rd(2*int'(m_w) + 1);
            end
            if (k == 2*W+1) busy = 0;
            k++;
        end
    end

    task automatic do_access(input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, output int stall);
        stall      = 0;
        rd_en      = r;
        wr_en      = w;
        address    = a;
        write_data = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) break;
            stall++;
        end
        if (stall >= 100) check("access_timeout", stall, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st, st2;
        logic [31:0] prev;
        logic [17:0] seen [$];

        rst_n = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        rd_1 = 0; addr_1 = 0;
        sram[4] = 16'hBEEF; sram[5] = 16'hDEAD;
        ref_half[4] = 16'hBEEF; ref_half[5] = 16'hDEAD;
        repeat (2) @(negedge clk);
        check("reset_ready_lit", ready, 1'b1);
        check("reset_pins_lit", {we_n, oe_n, ce_n, ub_n, lb_n, dq_oe}, 6'b111110);
        check("reset_addr_lit", sram_addr, 18'h0);
        @(posedge clk); #1;
        rst_n = 1;

        do_access(1, 0, 32'd1032, 32'h0, st);
        check("rd_stall_lit", st, 9);
        check("rd_word_lit", read_data, 32'hDEADBEEF);
        rd_en = 0;
        @(posedge clk); #1;

        we_cnt = 0;
        do_access(0, 1, 32'd1024, 32'h12345678, st);
        check("wr_stall_lit", st, 9);
        check("wr_we_cycles_lit", we_cnt, 8);
        check("wr_low_lit", env_rd(0), 16'h5678);
        check("wr_high_lit", env_rd(1), 16'h1234);

        do_access(0, 1, 32'd1060, 32'hCAFEBABE, st);
        do_access(1, 0, 32'd1060, 32'h0, st2);
        check("b2b_stall1_lit", st, 9);
        check("b2b_stall2_lit", st2, 9);
        check("b2b_word_lit", read_data, 32'hCAFEBABE);

        prev = read_data;
        do_access(1, 1, 32'd1028, 32'hA5A5A5A5, st);
        check("both_rd_keep", read_data, prev);
        check("both_wr_lit", {env_rd(3), env_rd(2)}, 32'hA5A5A5A5);
        rd_en = 0; wr_en = 0;
        @(posedge clk); #1;

        wr_en = 1; address = 32'd1040; write_data = 32'h0F0F1234;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 0; wr_en = 0;
        @(negedge clk);
        check("midrst_pins_lit", {we_n, oe_n, ce_n, ub_n, lb_n, dq_oe}, 6'b111110);
        check("midrst_ready_lit", ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("postrst_ready_lit", ready, 1'b1);
        @(posedge clk); #1;

        rd_1 = 1; addr_1 = 32'd1036; st = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ce_n_1) seen.push_back(sram_addr_1);
            if (ready_1) break;
            st++;
        end
        check("w1_stall_lit", st, 3);
        check("w1_halves_lit", seen.size(), 2);
        if (seen.size() == 2) begin
            check("w1_addr0_lit", seen[0], 18'd6);
            check("w1_addr1_lit", seen[1], 18'd7);
        end
        @(posedge clk); #1;
        rd_1 = 0;
        check("w1_word_lit", read_data_1, 32'hCAFEF00D);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0; rd_en = 0; wr_en = 0;
            end else begin
                rst_n = 1;
                if ($urandom_range(0, 2) != 0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: begin rd_en = 1; wr_en = 0; end
                        4, 5, 6, 7: begin rd_en = 0; wr_en = 1; end
                        8:          begin rd_en = 1; wr_en = 1; end
                        default:    begin rd_en = 0; wr_en = 0; end
                    endcase
                    if ($urandom_range(0, 15) == 0) address = $urandom_range(0, 1023);
                    else address = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                    write_data = $urandom;
                end
            end
            @(posedge clk); #1;
        end
        rst_n = 1; rd_en = 0; wr_en = 0;
        repeat (2*W + 4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Sequencer for the MEM stage's data-memory access.
- Converts the single-cycle MEM_R/MEM_W request, addressed by the EXE-stage ALU result, into a multi-cycle access on an external 16-bit asynchronous SRAM. Each 32-bit word is transferred as two 16-bit half-accesses.
- Drops ready while busy. The pipeline registers use ready as freeze (hold when 0), so the access completes before the instruction advances.

Parameters:
- WAIT_CYCLES, 4: clocks each 16-bit half-access is held on the SRAM bus. Legal range 1..15.
- BASE_ADDR, 1024: data-memory base subtracted from the byte address.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, active-low, asynchronous.
- wr_en  input  1  store request (MEM_W from the EXE/MEM register).
- rd_en  input  1  load request (MEM_R from the EXE/MEM register).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (Rm value).
- read_data  output  32  load result, registered.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_addr  output  18  SRAM halfword address.
- sram_dq_out  output  16  data driven to SRAM.
- sram_dq_in  input  16  data from SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the pad.
- sram_we_n  output  1  write enable, active-low.
- sram_oe_n  output  1  output enable, active-low.
- sram_ce_n  output  1  chip enable, active-low.
- sram_ub_n  output  1  upper byte lane enable, active-low.
- sram_lb_n  output  1  lower byte lane enable, active-low.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, wait counter = 0, read_data = 0.
  - sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0.
  - sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n all 1.
- ready = ~((rd_en | wr_en) & (state != DONE)). It is combinational and equals 1 while in reset with no request.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - All SRAM controls inactive.
  - If rd_en | wr_en, then on the clock edge latch op, word_addr and write_data, clear the counter, and go to LOW.
  - If both rd_en and wr_en are 1, the access is treated as a write.
- Address mapping: word_addr = (address - BASE_ADDR) >> 2, taking bits [16:0].
  - LOW half: sram_addr = {word_addr, 0}.
  - HIGH half: sram_addr = {word_addr, 1}.
- LOW and HIGH phases, each lasting exactly WAIT_CYCLES clocks:
  - In both phases: sram_ce_n = 0, ub_n = 0, lb_n = 0.
  - Write phase: sram_we_n = 0, sram_oe_n = 1, sram_dq_oe = 1. sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - Read phase: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Read capture: on the last clock of LOW, capture sram_dq_in into read_data[15:0]; on the last clock of HIGH, capture into read_data[31:16].
  - The counter increments each clock. At WAIT_CYCLES-1 it clears and the state advances: LOW→HIGH, HIGH→DONE.
- DONE:
  - Lasts one clock. SRAM controls are inactive and ready = 1, so the pipeline advances on this edge.
  - read_data holds the full word. It keeps that value until the next read's LOW capture; write accesses leave it unchanged.
  - Next state is IDLE unconditionally. A request present in IDLE is treated as the following instruction.
- Latency: request seen at cycle 0 gives ready = 0 for 2*WAIT_CYCLES+1 cycles, then ready = 1 in cycle 2*WAIT_CYCLES+1.
- Once latched, the access runs to completion even if rd_en, wr_en, address or write_data change mid-access.
- Reset mid-access: state and all outputs return to reset values immediately. No partial-write rollback.
- An address below BASE_ADDR wraps modulo 2^17 words and is not flagged.

Test Plan:
- Read, WAIT_CYCLES=4, address=1032, SRAM model holds halfwords [4]=0xBEEF and [5]=0xDEAD.
  - ready low 9 cycles, high in cycle 9; read_data = 0xDEADBEEF; sram_addr 4 then 5.
- Write 0x12345678 to address 1024.
  - sram_we_n low for 4 clocks at addr 0 with dq 0x5678, then 4 clocks at addr 1 with dq 0x1234; sram_dq_oe high during both; model word = 0x12345678.
- Back-to-back write then read of the same address, inputs held through freeze.
  - Two 9-cycle stalls separated by one IDLE cycle; read returns the written value.
- rd_en and wr_en both 1, write_data=0xA5A5A5A5, address=1028.
  - Write occurs; read_data unchanged from its prior value.
- Reset asserted during HIGH of a write.
  - All SRAM controls 1 and dq_oe 0 in the same cycle; state IDLE; after release with no request, ready = 1.
- WAIT_CYCLES=1 read.
  - ready low 3 cycles; each half captured after one clock; correct word returned.
